// File: rtl/canvas_brush_engine.sv
// canvas_brush_engine: clamped mouse cursor, full-screen clear sweep and
// clipped NxN brush stamping, one registered vga_adapter pixel per cycle.
// Ports: CLOCK_50, reset (sync, active-high); mouse_delta_x/y,
//   mouse_data_valid, left/right_button, draw_enable, brush_size,
//   pen/erase/clear_color, clear_request in; vga_x/y/color/write,
//   cursor_x/y, clearing_active, busy, clear_done out.
module canvas_brush_engine #(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240,
   parameter int X_BITS        = 9,
   parameter int Y_BITS        = 8,
   parameter int COLOR_DEPTH   = 9,
   parameter int INVERT_Y      = 1
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic [8:0]             mouse_delta_x,
   input  logic [8:0]             mouse_delta_y,
   input  logic                   mouse_data_valid,
   input  logic                   left_button,
   input  logic                   right_button,
   input  logic                   draw_enable,
   input  logic [1:0]             brush_size,
   input  logic [COLOR_DEPTH-1:0] pen_color,
   input  logic [COLOR_DEPTH-1:0] erase_color,
   input  logic [COLOR_DEPTH-1:0] clear_color,
   input  logic                   clear_request,
   output logic [X_BITS-1:0]      vga_x,
   output logic [Y_BITS-1:0]      vga_y,
   output logic [COLOR_DEPTH-1:0] vga_color,
   output logic                   vga_write,
   output logic [X_BITS-1:0]      cursor_x,
   output logic [Y_BITS-1:0]      cursor_y,
   output logic                   clearing_active,
   output logic                   busy,
   output logic                   clear_done
);
   localparam int XS = X_BITS + 2;
   localparam int YS = Y_BITS + 2;
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(SCREEN_WIDTH - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(SCREEN_HEIGHT - 1);
   localparam logic signed [XS-1:0] X_MAX_S = XS'(SCREEN_WIDTH - 1);
   localparam logic signed [YS-1:0] Y_MAX_S = YS'(SCREEN_HEIGHT - 1);
   localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(SCREEN_WIDTH);
   localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(SCREEN_HEIGHT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_STAMP
   } state_t;

   state_t state_q, state_d;

   logic [X_BITS-1:0]      clr_x_q, clr_x_d;
   logic [Y_BITS-1:0]      clr_y_q, clr_y_d;
   logic                   clr_end_q, clr_end_d;
   logic [X_BITS-1:0]      org_x_q, org_x_d;
   logic [Y_BITS-1:0]      org_y_q, org_y_d;
   logic [1:0]             sz_q, sz_d;
   logic [1:0]             off_i_q, off_i_d;
   logic [1:0]             off_j_q, off_j_d;
   logic [COLOR_DEPTH-1:0] col_q, col_d;
   logic                   hist_q, hist_d;
   logic [X_BITS-1:0]      last_x_q, last_x_d;
   logic [Y_BITS-1:0]      last_y_q, last_y_d;
   logic [X_BITS-1:0]      cur_x_q, cur_x_d;
   logic [Y_BITS-1:0]      cur_y_q, cur_y_d;
   logic [X_BITS-1:0]      vga_x_q, vga_x_d;
   logic [Y_BITS-1:0]      vga_y_q, vga_y_d;
   logic [COLOR_DEPTH-1:0] vga_color_q, vga_color_d;
   logic                   vga_write_q, vga_write_d;
   logic                   clear_done_q, clear_done_d;

   logic                   pen_down;
   logic                   trig;
   logic                   stamp_last;
   logic [X_BITS:0]        px;
   logic [Y_BITS:0]        py;
   logic                   px_in;
   logic signed [XS-1:0]   dx_s, sum_x;
   logic signed [YS-1:0]   dy_s, sum_y;

   assign pen_down   = draw_enable && (left_button || right_button);
   assign trig       = pen_down && (!hist_q ||
                       cur_x_q != last_x_q || cur_y_q != last_y_q);
   assign stamp_last = (off_i_q == sz_q) && (off_j_q == sz_q);
   assign px    = {1'b0, org_x_q} + (X_BITS+1)'(off_i_q);
   assign py    = {1'b0, org_y_q} + (Y_BITS+1)'(off_j_q);
   assign px_in = (px < X_LIM) && (py < Y_LIM);

   // State register and all datapath flops
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_CLEAR;
         clr_x_q      <= '0;
         clr_y_q      <= '0;
         clr_end_q    <= 1'b0;
         org_x_q      <= '0;
         org_y_q      <= '0;
         sz_q         <= '0;
         off_i_q      <= '0;
         off_j_q      <= '0;
         col_q        <= '0;
         hist_q       <= 1'b0;
         last_x_q     <= '0;
         last_y_q     <= '0;
         cur_x_q      <= X_BITS'(SCREEN_WIDTH / 2);
         cur_y_q      <= Y_BITS'(SCREEN_HEIGHT / 2);
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_color_q  <= '0;
         vga_write_q  <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_x_q      <= clr_x_d;
         clr_y_q      <= clr_y_d;
         clr_end_q    <= clr_end_d;
         org_x_q      <= org_x_d;
         org_y_q      <= org_y_d;
         sz_q         <= sz_d;
         off_i_q      <= off_i_d;
         off_j_q      <= off_j_d;
         col_q        <= col_d;
         hist_q       <= hist_d;
         last_x_q     <= last_x_d;
         last_y_q     <= last_y_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_color_q  <= vga_color_d;
         vga_write_q  <= vga_write_d;
         clear_done_q <= clear_done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (clear_request)  state_d = S_CLEAR;
            else if (trig)      state_d = S_STAMP;
         end
         S_CLEAR: begin
            if (clr_end_q)      state_d = S_IDLE;
         end
         S_STAMP: begin
            if (clear_request)  state_d = S_CLEAR;
            else if (stamp_last) state_d = S_IDLE;
         end
         default:               state_d = S_CLEAR;
      endcase
   end

   // Pixel output and sweep/stamp bookkeeping
   always_comb begin
      clr_x_d      = clr_x_q;
      clr_y_d      = clr_y_q;
      clr_end_d    = clr_end_q;
      org_x_d      = org_x_q;
      org_y_d      = org_y_q;
      sz_d         = sz_q;
      off_i_d      = off_i_q;
      off_j_d      = off_j_q;
      col_d        = col_q;
      hist_d       = hist_q;
      last_x_d     = last_x_q;
      last_y_d     = last_y_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_color_d  = vga_color_q;
      vga_write_d  = 1'b0;
      clear_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clear_request) begin
               clr_x_d   = '0;
               clr_y_d   = '0;
               clr_end_d = 1'b0;
            end else if (trig) begin
               org_x_d  = cur_x_q;
               org_y_d  = cur_y_q;
               sz_d     = brush_size;
               off_i_d  = '0;
               off_j_d  = '0;
               col_d    = right_button ? erase_color : pen_color;
               hist_d   = 1'b1;
               last_x_d = cur_x_q;
               last_y_d = cur_y_q;
            end else if (!pen_down) begin
               hist_d = 1'b0;
            end
         end
         S_CLEAR: begin
            if (clr_end_q) begin
               clear_done_d = 1'b1;
               hist_d       = 1'b0;
            end else begin
               vga_x_d     = clr_x_q;
               vga_y_d     = clr_y_q;
               vga_color_d = clear_color;
               vga_write_d = 1'b1;
               if (clr_x_q == X_LAST) begin
                  clr_x_d = '0;
                  if (clr_y_q == Y_LAST) clr_end_d = 1'b1;
                  else clr_y_d = clr_y_q + Y_BITS'(1);
               end else begin
                  clr_x_d = clr_x_q + X_BITS'(1);
               end
            end
         end
         S_STAMP: begin
            if (clear_request) begin
               // Abort presents (0,0) at once; sweep resumes at (1,0)
               vga_x_d     = '0;
               vga_y_d     = '0;
               vga_color_d = clear_color;
               vga_write_d = 1'b1;
               clr_x_d     = X_BITS'(1);
               clr_y_d     = '0;
               clr_end_d   = 1'b0;
            end else begin
               vga_x_d     = X_BITS'(px);
               vga_y_d     = Y_BITS'(py);
               vga_color_d = col_q;
               vga_write_d = px_in;
               if (off_i_q == sz_q) begin
                  off_i_d = '0;
                  off_j_d = off_j_q + 2'd1;
               end else begin
                  off_i_d = off_i_q + 2'd1;
               end
            end
         end
         default: ;
      endcase
   end

   // Cursor: widened signed add, then per-axis clamp
   always_comb begin
      dx_s = XS'($signed(mouse_delta_x));
      dy_s = YS'($signed(mouse_delta_y));
      if (INVERT_Y != 0) dy_s = -dy_s;
      sum_x   = $signed({2'b00, cur_x_q}) + dx_s;
      sum_y   = $signed({2'b00, cur_y_q}) + dy_s;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      if (mouse_data_valid) begin
         if (sum_x[XS-1])         cur_x_d = '0;
         else if (sum_x > X_MAX_S) cur_x_d = X_LAST;
         else                      cur_x_d = X_BITS'(sum_x);
         if (sum_y[YS-1])         cur_y_d = '0;
         else if (sum_y > Y_MAX_S) cur_y_d = Y_LAST;
         else                      cur_y_d = Y_BITS'(sum_y);
      end
   end

   assign vga_x           = vga_x_q;
   assign vga_y           = vga_y_q;
   assign vga_color       = vga_color_q;
   assign vga_write       = vga_write_q;
   assign cursor_x        = cur_x_q;
   assign cursor_y        = cur_y_q;
   assign clear_done      = clear_done_q;
   assign clearing_active = (state_q == S_CLEAR);
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_canvas_brush_engine.sv
// tb_canvas_brush_engine: small 8x4 instance checked every cycle against a
// pixel-queue model, plus a 320x32 instance for cursor/stamp sequences.
module tb_canvas_brush_engine;
   localparam int AW = 8;
   localparam int AH = 4;
   localparam int BW = 320;
   localparam int BH = 32;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [8:0] mdx, mdy;
   logic       mval, lb, rb, den, creq;
   logic [1:0] bsz;
   logic [8:0] pen_c, era_c, clr_c;

   logic [8:0] a_x, a_c, a_cx, b_x, b_c, b_cx;
   logic [7:0] a_y, a_cy, b_y, b_cy;
   logic       a_w, a_clr, a_busy, a_done;
   logic       b_w, b_clr, b_busy, b_done;

   canvas_brush_engine #(.SCREEN_WIDTH(AW), .SCREEN_HEIGHT(AH)) u_a (
      .CLOCK_50(clk), .reset(reset),
      .mouse_delta_x(mdx), .mouse_delta_y(mdy),
      .mouse_data_valid(mval), .left_button(lb), .right_button(rb),
      .draw_enable(den), .brush_size(bsz), .pen_color(pen_c),
      .erase_color(era_c), .clear_color(clr_c), .clear_request(creq),
      .vga_x(a_x), .vga_y(a_y), .vga_color(a_c), .vga_write(a_w),
      .cursor_x(a_cx), .cursor_y(a_cy), .clearing_active(a_clr),
      .busy(a_busy), .clear_done(a_done)
   );

   canvas_brush_engine #(.SCREEN_WIDTH(BW), .SCREEN_HEIGHT(BH)) u_b (
      .CLOCK_50(clk), .reset(reset),
      .mouse_delta_x(mdx), .mouse_delta_y(mdy),
      .mouse_data_valid(mval), .left_button(lb), .right_button(rb),
      .draw_enable(den), .brush_size(bsz), .pen_color(pen_c),
      .erase_color(era_c), .clear_color(clr_c), .clear_request(creq),
      .vga_x(b_x), .vga_y(b_y), .vga_color(b_c), .vga_write(b_w),
      .cursor_x(b_cx), .cursor_y(b_cy), .clearing_active(b_clr),
      .busy(b_busy), .clear_done(b_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mv(input logic [8:0] dx, input logic [8:0] dy);
      mdx = dx; mdy = dy; mval = 1'b1;
      step();
      mval = 1'b0; mdx = '0; mdy = '0;
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   // Reference model for instance A: every future output cycle is a queue
   // entry; kind 0 = clear pixel, 1 = stamp pixel, 2 = clear-done slot.
   typedef struct {
      int         x;
      int         y;
      int         kind;
      int         w;
      logic [8:0] c;
   } pix_t;

   pix_t       mq[$];
   bit         m_mclr = 1'b1;
   bit         m_hist = 1'b0;
   int         m_cx = AW / 2, m_cy = AH / 2, m_lx = 0, m_ly = 0;
   bit         e_w = 0, e_done = 0, e_busy = 1, e_clr = 1;
   int         e_x = 0, e_y = 0;
   logic [8:0] e_c = '0;

   task automatic fill_clear();
      mq.delete();
      for (int y = 0; y < AH; y++)
         for (int x = 0; x < AW; x++)
            mq.push_back('{x: x, y: y, kind: 0, w: 1, c: '0});
      mq.push_back('{x: 0, y: 0, kind: 2, w: 0, c: '0});
   endtask

   task automatic model_step();
      pix_t p;
      int   s, d;
      if (reset) begin
         fill_clear();
         m_mclr = 1; m_hist = 0;
         m_cx = AW / 2; m_cy = AH / 2;
         e_w = 0; e_done = 0; e_x = 0; e_y = 0; e_c = '0;
      end else begin
         e_w = 0; e_done = 0;
         if (mq.size() == 0) begin
            if (creq) begin
               fill_clear();
               m_mclr = 1;
            end else if (den && (lb || rb) &&
                         (!m_hist || m_cx != m_lx || m_cy != m_ly)) begin
               s = int'(bsz) + 1;
               for (int j = 0; j < s; j++)
                  for (int i = 0; i < s; i++)
                     mq.push_back('{x: m_cx + i, y: m_cy + j, kind: 1,
                                    w: int'((m_cx + i < AW) && (m_cy + j < AH)),
                                    c: rb ? era_c : pen_c});
               m_hist = 1; m_lx = m_cx; m_ly = m_cy; m_mclr = 0;
            end else if (!(den && (lb || rb))) begin
               m_hist = 0;
            end
         end else begin
            if (!m_mclr && creq) begin
               fill_clear();
               m_mclr = 1;
            end
            p = mq.pop_front();
            if (p.kind == 2) begin
               e_done = 1;
               m_hist = 0;
            end else begin
               e_w = (p.w != 0);
               if (p.w != 0) begin
                  e_x = p.x; e_y = p.y;
                  e_c = (p.kind == 0) ? clr_c : p.c;
               end
            end
         end
         if (mval) begin
            d = $signed(mdx);
            m_cx = clampi(m_cx + d, AW - 1);
            d = $signed(mdy);
            m_cy = clampi(m_cy - d, AH - 1);
         end
      end
      e_busy = (mq.size() != 0);
      e_clr  = e_busy && m_mclr;
   endtask

   bit mon_on = 1'b1;
   always begin
      @(posedge clk);
      model_step();
      #2;
      if (mon_on) begin
         chk("a_write", a_w, e_w);
         if (e_w) begin
            chk("a_x", a_x, e_x);
            chk("a_y", a_y, e_y);
            chk("a_color", a_c, e_c);
         end
         chk("a_clear_done", a_done, e_done);
         chk("a_busy", a_busy, e_busy);
         chk("a_clearing", a_clr, e_clr);
         chk("a_cursor_x", a_cx, m_cx);
         chk("a_cursor_y", a_cy, m_cy);
      end
   end

   typedef struct {
      logic [8:0] dx;
      logic [8:0] dy;
      int         ex;
      int         ey;
   } cvec_t;

   cvec_t cv[8];
   int    n, got, first, done_at, busy_cnt;

   initial begin
      cv[0] = '{9'd100, 9'd0,   260, 16};
      cv[1] = '{9'd100, 9'd0,   319, 16};
      cv[2] = '{9'h138, 9'd0,   119, 16};
      cv[3] = '{9'd0,   9'd200, 119, 0};
      cv[4] = '{9'd0,   9'h1FB, 119, 5};
      cv[5] = '{9'h100, 9'd0,   0,   5};
      cv[6] = '{9'd0,   9'h19C, 0,   31};
      cv[7] = '{9'd255, 9'd3,   255, 28};

      reset = 1; mval = 0; mdx = '0; mdy = '0; lb = 0; rb = 0;
      den = 1; bsz = '0; pen_c = '0; era_c = '0; clr_c = 9'h1FF;
      creq = 0;
      step(); step();
      chk("rst_write", a_w, 0);
      chk("rst_vga_x", a_x, 0);
      chk("rst_vga_y", a_y, 0);
      chk("rst_color", a_c, 0);
      chk("rst_done", a_done, 0);
      chk("rst_busy", a_busy, 1);
      chk("rst_cursor_bx", b_cx, BW / 2);
      chk("rst_cursor_by", b_cy, BH / 2);
      reset = 0;

      // Full clear of the 8x4 instance
      n = 0; first = -1; done_at = -1;
      for (int c = 1; c <= 40 && done_at < 0; c++) begin
         step();
         if (a_w) begin
            if (first < 0) first = c;
            chk("t1_x", a_x, n % AW);
            chk("t1_y", a_y, n / AW);
            chk("t1_color", a_c, 9'h1FF);
            n++;
         end
         if (a_done) begin
            done_at = c;
            chk("t1_busy_at_done", a_busy, 0);
         end
      end
      chk("t1_writes", n, AW * AH);
      chk("t1_first_cycle", first, 1);
      chk("t1_done_cycle", done_at, AW * AH + 1);

      chk("b_clearing", b_clr, 1);
      got = 0;
      for (int c = 0; c < 11000 && got == 0; c++) begin
         step();
         if (b_done) got = 1;
      end
      chk("b_clear_done_seen", got, 1);
      chk("b_idle", b_busy, 0);

      // Cursor clamping vectors on the 320-wide instance
      for (int k = 0; k < 8; k++) begin
         mv(cv[k].dx, cv[k].dy);
         chk($sformatf("t2_cx_%0d", k), b_cx, cv[k].ex);
         chk($sformatf("t2_cy_%0d", k), b_cy, cv[k].ey);
      end

      // 2x2 pen stamp at (100,20), single stamp while held
      mv(9'h100, 9'd255); mv(9'h100, 9'd255);
      mv(9'd100, 9'h1EC);
      chk("t3_pre_x", b_cx, 100);
      chk("t3_pre_y", b_cy, 20);
      pen_c = 9'h1C0; bsz = 2'd1; lb = 1;
      n = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (b_w) begin
            chk("t3_cycle", c, 2 + n);
            chk("t3_x", b_x, 100 + n % 2);
            chk("t3_y", b_y, 20 + n / 2);
            chk("t3_color", b_c, 9'h1C0);
            n++;
         end
      end
      chk("t3_writes", n, 4);
      lb = 0; step();

      // 4x4 stamp at the bottom-right corner: 16 busy cycles, 1 write
      mv(9'd255, 9'h19C); mv(9'd255, 9'h19C);
      chk("t4_pre_x", b_cx, BW - 1);
      chk("t4_pre_y", b_cy, BH - 1);
      bsz = 2'd3; lb = 1;
      n = 0; busy_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (b_busy) busy_cnt++;
         if (b_w) begin
            chk("t4_cycle", c, 2);
            chk("t4_x", b_x, BW - 1);
            chk("t4_y", b_y, BH - 1);
            n++;
         end
      end
      chk("t4_writes", n, 1);
      chk("t4_busy_cycles", busy_cnt, 16);
      lb = 0; step();

      // Erase wins when both held; nothing with draw_enable low
      era_c = 9'h000; bsz = 2'd0; lb = 1; rb = 1;
      n = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (b_w) begin
            chk("t5_cycle", c, 2);
            chk("t5_color", b_c, 9'h000);
            chk("t5_x", b_x, BW - 1);
            n++;
         end
      end
      chk("t5_writes", n, 1);
      lb = 0; rb = 0; step();
      den = 0; lb = 1; rb = 1;
      n = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (b_w) n++;
      end
      chk("t5_disabled_writes", n, 0);
      lb = 0; rb = 0; den = 1;
      repeat (20) step();

      // Clear request aborts a 4x4 stamp on the 8x4 instance
      clr_c = 9'h0AA; bsz = 2'd3; lb = 1;
      step();
      chk("t6_stamp_busy", a_busy, 1);
      chk("t6_not_clearing", a_clr, 0);
      step();
      creq = 1;
      step();
      creq = 0; lb = 0;
      chk("t6_abort_write", a_w, 1);
      chk("t6_abort_x", a_x, 0);
      chk("t6_abort_y", a_y, 0);
      chk("t6_abort_color", a_c, 9'h0AA);
      chk("t6_clearing", a_clr, 1);
      n = 1; got = 0;
      for (int c = 0; c < 60 && got == 0; c++) begin
         step();
         if (a_w) n++;
         if (a_done) got = 1;
      end
      chk("t6_clear_writes", n, AW * AH);
      chk("t6_done_seen", got, 1);

      // Random traffic, checked cycle by cycle against the model
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         mval  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) begin
            mdx = 9'($urandom);
            mdy = 9'($urandom);
         end else begin
            mdx = 9'(int'($urandom_range(0, 6)) - 3);
            mdy = 9'(int'($urandom_range(0, 6)) - 3);
         end
         if ($urandom_range(0, 7) == 0) lb = 1'($urandom);
         if ($urandom_range(0, 11) == 0) rb = 1'($urandom);
         den   = ($urandom_range(0, 15) != 0);
         bsz   = 2'($urandom);
         pen_c = 9'($urandom);
         era_c = 9'($urandom);
         clr_c = 9'($urandom);
         creq  = ($urandom_range(0, 79) == 0);
         step();
      end
      reset = 0; creq = 0; mval = 0; lb = 0; rb = 0;
      step(); step();
      mon_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
